// File: rtl/psum_ofifo_pkg.sv
// Shared sizing constants for the systolic-array output FIFO.
package psum_ofifo_pkg;

  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 16;
  // One extra pointer bit distinguishes full from empty when the low bits match.
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column psum FIFO with show-ahead head output.
// The pop strobe arrives already qualified by the top level.
module psum_col_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int width = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] in,
  output logic [width-1:0] out,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(depth);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [width-1:0] mem [depth];
  logic             push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  // The full check uses pre-edge state, so a write to a full column is lost
  // even when the same edge pops it.
  assign push  = wr & ~full;
  assign drop  = wr & full;
  assign out   = mem[rptr[AW-1:0]];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= in;
    end
  end

  // Read/write pointers wrap naturally modulo 2*depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_ofifo.sv
// Output buffer below the MAC array: one FIFO per column absorbs the skewed
// column completion times so a whole row can be popped in a single cycle.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   full,
  output logic                   ready,
  output logic                   overflow,
  output logic                   underflow
);

  logic [col-1:0]         col_empty;
  logic [col-1:0]         col_full;
  logic [col-1:0]         col_drop;
  logic [col*psum_bw-1:0] head;
  logic                   pop;

  // Status is derived from pointer state only, never from the inputs.
  assign o_valid = ~|col_empty;
  assign full    = |col_full;
  assign ready   = ~full;
  // A row is popped only when every column has data, keeping columns aligned.
  assign pop     = rd & o_valid;
  assign out     = o_valid ? head : '0;

  for (genvar i = 0; i < col; i++) begin : g_col
    psum_col_fifo #(
      .width(psum_bw),
      .depth(depth)
    ) u_col (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[i]),
      .rd   (pop),
      .in   (in[i*psum_bw +: psum_bw]),
      .out  (head[i*psum_bw +: psum_bw]),
      .empty(col_empty[i]),
      .full (col_full[i]),
      .drop (col_drop[i])
    );
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (|col_drop) begin
        overflow <= 1'b1;
      end
      if (rd && !o_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo (8 columns x 16 bits, depth 16).
`timescale 1ns/1ps
module tb_psum_ofifo;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   wr;
  logic [127:0] in;
  logic         rd;
  logic [127:0] out;
  logic         o_valid;
  logic         full;
  logic         ready;
  logic         overflow;
  logic         underflow;

  int n_cmp = 0;
  int n_bad = 0;

  psum_ofifo dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .in       (in),
    .rd       (rd),
    .out      (out),
    .o_valid  (o_valid),
    .full     (full),
    .ready    (ready),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same 16-bit value in every column.
  function automatic logic [127:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Distinct per-column pattern: column c of row k holds k*16+c.
  function automatic logic [127:0] row(input int k);
    logic [127:0] r;
    for (int c = 0; c < 8; c++) r[c*16 +: 16] = 16'(k*16 + c);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (out !== 128'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_skewed_fill();
    logic [127:0] exp_row;
    exp_row = '0;
    for (int c = 0; c < 8; c++) begin
      wr = 8'(1 << c);
      in = '0;
      in[c*16 +: 16] = 16'(17 * (c + 1));
      exp_row[c*16 +: 16] = 16'(17 * (c + 1));
      tick();
      if (c < 7) begin
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL skew_o_valid_early col%0d: got %b want 0", c, o_valid); end
      end
    end
    wr = '0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL skew_o_valid: got %b want 1", o_valid); end
    n_cmp++; if (out !== exp_row) begin n_bad++; $display("FAIL skew_out: got %h want %h", out, exp_row); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL skew_pop_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL skew_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL fill_full_early k%0d: got %b want 0", k, full); end
      wr = 8'hFF; in = rep(16'(k));
      tick();
    end
    wr = '0;
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow_early: got %b want 0", overflow); end
    wr = 8'hFF; in = rep(16'hFFFF);
    tick();
    wr = '0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_overflow: got %b want 1", overflow); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full_after_drop: got %b want 1", full); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (out !== rep(16'(k))) begin n_bad++; $display("FAIL pop_out k%0d: got %h want %h", k, out, rep(16'(k))); end
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL pop_empty_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL pop_empty_full: got %b want 0", full); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL pop_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_wrap();
    wr = 8'hFF; in = row(0);
    tick();
    for (int k = 1; k <= 40; k++) begin
      n_cmp++; if (out !== row(k - 1)) begin n_bad++; $display("FAIL wrap_out k%0d: got %h want %h", k, out, row(k - 1)); end
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL wrap_full k%0d: got %b want 0", k, full); end
      wr = 8'hFF; in = row(k); rd = 1'b1;
      tick();
    end
    wr = '0; rd = 1'b0;
    n_cmp++; if (out !== row(40)) begin n_bad++; $display("FAIL wrap_last: got %h want %h", out, row(40)); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_drain_o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_underflow();
    logic [127:0] exp_row;
    for (int c = 0; c < 8; c++) exp_row[c*16 +: 16] = 16'hA0 + 16'(c);
    wr = 8'b1111_0111; in = exp_row;
    tick();
    wr = '0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL uf_o_valid: got %b want 0", o_valid); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL uf_flag: got %b want 1", underflow); end
    wr = 8'b0000_1000; in = exp_row;
    tick();
    wr = '0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL uf_refill_o_valid: got %b want 1", o_valid); end
    n_cmp++; if (out !== exp_row) begin n_bad++; $display("FAIL uf_retained: got %h want %h", out, exp_row); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL uf_drain_o_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      wr = 8'hFF; in = row(100 + k);
      tick();
    end
    wr = '0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre_o_valid: got %b want 1", o_valid); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL ar_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL ar_full: got %b want 0", full); end
    n_cmp++; if (out !== 128'h0) begin n_bad++; $display("FAIL ar_out: got %h want 0", out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ar_overflow: got %b want 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL ar_underflow: got %b want 0", underflow); end
    tick();
    reset = 1'b0;
    wr = 8'hFF; in = row(200);
    tick();
    wr = '0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL ar_after_o_valid: got %b want 1", o_valid); end
    n_cmp++; if (out !== row(200)) begin n_bad++; $display("FAIL ar_after_out: got %h want %h", out, row(200)); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL ar_single_entry: got %b want 0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_skewed_fill();
    test_fill_overflow();
    test_wrap();
    test_underflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
Output buffer directly downstream of the bottom row of the systolic MAC array.
- Captures the per-column partial sums leaving the array's south edge, one independent FIFO per column, each written by that column's valid bit.
- Columns finish at skewed cycles. This block re-aligns them: a full row of results can be popped in one cycle by the SFU/accumulation stage or the psum SRAM writer.

Parameters:
col, 8, number of array columns (independent column FIFOs)
psum_bw, 16, partial-sum width per column in bits
depth, 16, entries per column FIFO (power of two, >= 2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
wr  input  col  per-column write strobe; wired to the array's valid[col-1:0]
in  input  col*psum_bw  per-column psums; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]
rd  input  1  pop one entry from every column; honoured only when o_valid=1
out  output  col*psum_bw  head entry of every column (show-ahead); same column packing as in
o_valid  output  1  every column FIFO is non-empty; a full row is available
full  output  1  at least one column FIFO holds depth entries
ready  output  1  equals not full; upstream must not issue new array instructions when low
overflow  output  1  sticky: a write was dropped on a full column
underflow  output  1  sticky: rd was asserted while o_valid=0

Behaviour:
- Reset (async assert, sync release): all read/write pointers = 0, o_valid=0, full=0, ready=1, overflow=0, underflow=0, out=0. Memory contents are not reset.
- A reset asserted mid-operation discards all buffered data immediately.
- Pointers are log2(depth)+1 bits wide (wrap bit).
  - Column empty when wptr==rptr.
  - Column full when the low bits are equal and the wrap bits differ.
  - Pointers wrap modulo 2*depth with no special case.
- Write, column i, at a rising edge:
  - If wr[i]=1 and column i is not full: store in slice i at wptr[i], then increment wptr[i].
  - If wr[i]=1 and column i is full: data is dropped, wptr[i] is unchanged, and overflow is set to 1.
  - Columns are written independently; any subset of wr may be high in a cycle.
- Read, at a rising edge:
  - If rd=1 and o_valid=1: every rptr increments.
  - If rd=1 and o_valid=0: no pointer moves, and underflow is set to 1.
- Simultaneous read and write:
  - Both take effect in the same cycle.
  - The full check for a write uses the pre-edge state: a write to a column that is full is dropped even if rd pops it in the same cycle.
  - Simultaneous rd and wr on a column holding one entry leaves it holding one entry (the new data).
- Latency: data written at edge N is visible on out, with o_valid updated, after edge N (combinational from registered state). Write-to-read latency is 1 cycle.
- Output timing:
  - o_valid = AND over all columns of not-empty; full = OR over columns of column-full; ready = not full. All are combinational from pointers, with no input-to-output combinational path.
  - out slice i = mem_i[rptr_i] when o_valid=1, else all zeros.
- Arithmetic: pure storage. psum values pass bit-exact with no sign extension or truncation.
- overflow and underflow clear only on reset.

Decomposition:
- Shared package: localparams PSUM_BW=16, COL=8, OFIFO_DEPTH=16, plus a clog2-derived pointer-width constant.
- Sub-module psum_col_fifo (width, depth): a single-column FIFO.
  - Ports: clk, reset, wr, rd, in, out, empty, full, drop.
  - Instantiated col times in a generate loop.
  - The top level forms o_valid, full, ready, the rd gating (rd & o_valid) and the sticky flags.

Test Plan:
- Reset then idle -> o_valid=0, full=0, ready=1, out=0, overflow=0, underflow=0.
- Skewed fill: drive wr=8'b0000_0001 with col0=0x0011, then advance one column per cycle until column 7 is written with 0x0088 at cycle 7.
  - Required: o_valid stays 0 until the cycle after the column-7 write.
  - Then out = {0x0088,...,0x0011}.
  - rd=1 for one cycle -> o_valid=0.
- Fill all columns with 16 writes of values 0..15.
  - After the 16th write: full=1, ready=0.
  - A 17th write of 0xFFFF -> overflow=1.
  - 16 pops return 0..15 in order; 0xFFFF never appears.
- Wrap-around: 40 cycles of concurrent wr=all-ones plus rd (after one priming write), with an incrementing pattern.
  - Required: every popped row equals the row written one cycle earlier.
  - full stays 0 and pointers wrap cleanly.
- rd=1 with column 3 empty and the others non-empty -> no pointer moves, underflow=1, other columns retain data.
- Reset asserted asynchronously mid-fill (5 entries per column) -> o_valid and full drop immediately without a clock edge, out=0.
  - After release, a single full-row write reappears at out.
